// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: widths, canonical NOP, major opcodes and
// the fetch-stage state encoding.
package riscv_pkg;

  localparam int DEFAULT_XLEN = 32;

  localparam logic [6:0] OPC_R_TYPE = 7'b0110011;
  localparam logic [6:0] OPC_I_TYPE = 7'b0010011;
  localparam logic [6:0] OPC_LW     = 7'b0000011;
  localparam logic [6:0] OPC_SW     = 7'b0100011;
  localparam logic [6:0] OPC_BR     = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = {12'h000, 5'd0, 3'b000, 5'd0, OPC_I_TYPE};

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bundle between the fetch stage
// (master) and a synchronous-read instruction memory (slave).
interface fetch_stage_if #(
  parameter int XLEN = riscv_pkg::DEFAULT_XLEN
);
  logic            imem_req_o;
  logic [XLEN-1:0] imem_addr_o;
  logic [31:0]     imem_rdata_i;

  modport master (output imem_req_o, output imem_addr_o, input imem_rdata_i);
  modport slave  (input imem_req_o, input imem_addr_o, output imem_rdata_i);
endinterface

// File: rtl/if_id_skid.sv
// One-entry {pc, instr} holding buffer that catches the memory response
// which lands while the IF/ID register is stalled.
module if_id_skid #(
  parameter int XLEN = riscv_pkg::DEFAULT_XLEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load_i,
  input  logic            clear_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [31:0]     instr_i,
  output logic            valid_o,
  output logic [XLEN-1:0] pc_o,
  output logic [31:0]     instr_o
);

  logic            valid_q;
  logic [XLEN-1:0] pc_q;
  logic [31:0]     instr_q;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // flop samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      instr_q <= riscv_pkg::NOP_INSTR;
    end else if (clear_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      pc_q    <= pc_i;
      instr_q <= instr_i;
    end
  end

  assign valid_o = valid_q;
  assign pc_o    = pc_q;
  assign instr_o = instr_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register: PC generation,
// one-cycle memory latency absorption under stall, and EX redirects.
module fetch_stage
  import riscv_pkg::*;
#(
  parameter int              XLEN     = DEFAULT_XLEN,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall_i,
  input  logic              redirect_i,
  input  logic [XLEN-1:0]   redirect_pc_i,
  fetch_stage_if.master     imem,
  output logic              id_valid_o,
  output logic [XLEN-1:0]   id_pc_o,
  output logic [XLEN-1:0]   id_pc_plus4_o,
  output logic [31:0]       id_instr_o,
  output logic [6:0]        id_opcode_o,
  output logic              misalign_o
);

  fetch_state_e    state_q;
  logic [XLEN-1:0] pc_q;
  logic            inflight_q;
  logic [XLEN-1:0] inflight_pc_q;
  logic            fetch_req;

  logic            id_valid_q;
  logic [XLEN-1:0] id_pc_q;
  logic [XLEN-1:0] id_pc_plus4_q;
  logic [31:0]     id_instr_q;
  logic [6:0]      id_opcode_q;
  logic            misalign_q;

  logic            id_load;
  logic            id_valid_d;
  logic [XLEN-1:0] id_pc_d;
  logic [31:0]     id_instr_d;

  logic            skid_load;
  logic            skid_clear;
  logic            skid_valid;
  logic [XLEN-1:0] skid_pc;
  logic [31:0]     skid_instr;

  assign fetch_req        = (state_q != BOOT) && !stall_i && !redirect_i;
  assign imem.imem_req_o  = fetch_req;
  assign imem.imem_addr_o = pc_q;

  // A response arriving under stall is parked; it is released (or flushed)
  // the first cycle the stall drops.
  assign skid_load  = !redirect_i && stall_i && inflight_q;
  assign skid_clear = redirect_i || (!stall_i && state_q == HOLD);

  if_id_skid #(.XLEN(XLEN)) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (skid_load),
    .clear_i (skid_clear),
    .pc_i    (inflight_pc_q),
    .instr_i (imem.imem_rdata_i),
    .valid_o (skid_valid),
    .pc_o    (skid_pc),
    .instr_o (skid_instr)
  );

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    id_load    = 1'b1;
    id_valid_d = 1'b0;
    id_pc_d    = id_pc_q;
    id_instr_d = NOP_INSTR;
    if (redirect_i) begin
      id_load = 1'b1;
    end else if (stall_i) begin
      id_load = 1'b0;
    end else if (state_q == HOLD) begin
      id_valid_d = 1'b1;
      id_pc_d    = skid_pc;
      id_instr_d = skid_instr;
    end else if (inflight_q) begin
      id_valid_d = 1'b1;
      id_pc_d    = inflight_pc_q;
      id_instr_d = imem.imem_rdata_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= BOOT;
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      id_valid_q    <= 1'b0;
      id_pc_q       <= '0;
      id_pc_plus4_q <= XLEN'(4);
      id_instr_q    <= NOP_INSTR;
      id_opcode_q   <= NOP_INSTR[6:0];
      misalign_q    <= 1'b0;
    end else begin
      inflight_q    <= fetch_req;
      inflight_pc_q <= pc_q;
      misalign_q    <= redirect_i && (redirect_pc_i[1:0] != 2'b00);

      if (redirect_i) begin
        pc_q <= {redirect_pc_i[XLEN-1:2], 2'b00};
      end else if (fetch_req) begin
        pc_q <= pc_q + XLEN'(4);
      end

      if (redirect_i) begin
        state_q <= (state_q == BOOT) ? BOOT : RUN;
      end else if (stall_i) begin
        if (inflight_q)            state_q <= HOLD;
        else if (state_q == BOOT)  state_q <= RUN;
      end else begin
        state_q <= RUN;
      end

      if (id_load) begin
        id_valid_q    <= id_valid_d;
        id_pc_q       <= id_pc_d;
        id_pc_plus4_q <= id_pc_d + XLEN'(4);
        id_instr_q    <= id_instr_d;
        id_opcode_q   <= id_instr_d[6:0];
      end
    end
  end

  // Depth one suffices only because no request issues while parked.
  assert property (@(posedge clk) disable iff (!rst_n)
                   !(inflight_q && state_q == HOLD));
  assert property (@(posedge clk) disable iff (!rst_n)
                   (state_q == HOLD) == skid_valid);

  assign id_valid_o    = id_valid_q;
  assign id_pc_o       = id_pc_q;
  assign id_pc_plus4_o = id_pc_plus4_q;
  assign id_instr_o    = id_instr_q;
  assign id_opcode_o   = id_opcode_q;
  assign misalign_o    = misalign_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed start-up/stall/redirect/wrap/
// reset scenarios plus random stall/redirect traffic against a queue model.
module tb_fetch_stage;
  import riscv_pkg::*;

  localparam int          XLEN     = 32;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        id_valid;
  logic [31:0] id_pc, id_pc_plus4, id_instr;
  logic [6:0]  id_opcode;
  logic        misalign;

  int checks = 0;
  int failures = 0;

  fetch_stage_if #(.XLEN(XLEN)) imem_bus ();

  fetch_stage #(.XLEN(XLEN), .RESET_PC(RESET_PC)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall_i       (stall),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .imem          (imem_bus),
    .id_valid_o    (id_valid),
    .id_pc_o       (id_pc),
    .id_pc_plus4_o (id_pc_plus4),
    .id_instr_o    (id_instr),
    .id_opcode_o   (id_opcode),
    .misalign_o    (misalign)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h1000_0000 + {2'b00, a[31:2]};
  endfunction

  always @(posedge clk)
    if (imem_bus.imem_req_o) imem_bus.imem_rdata_i <= mem_word(imem_bus.imem_addr_o);

  // Reference model: program-order queues of fetched PCs.
  bit          m_boot;
  logic [31:0] m_fetch_pc;
  logic [31:0] m_arrive[$];
  logic [31:0] m_wait[$];
  bit          m_slot_valid;
  logic [31:0] m_slot_pc;
  bit          m_misalign;
  logic        seen_req;
  logic [31:0] seen_addr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_boot = 1'b1;
    m_fetch_pc = RESET_PC;
    m_arrive.delete();
    m_wait.delete();
    m_slot_valid = 1'b0;
    m_slot_pc = '0;
    m_misalign = 1'b0;
  endtask

  task automatic model_clock();
    logic [31:0] old[$];
    bit req;
    req = !m_boot && !stall && !redirect;
    old = m_arrive;
    m_arrive.delete();
    if (req) begin
      m_arrive.push_back(m_fetch_pc);
      m_fetch_pc = m_fetch_pc + 32'd4;
    end
    m_misalign = redirect && (redirect_pc[1:0] != 2'b00);
    if (redirect) begin
      m_wait.delete();
      m_slot_valid = 1'b0;
      m_fetch_pc = {redirect_pc[31:2], 2'b00};
    end else begin
      m_boot = 1'b0;
      foreach (old[i]) m_wait.push_back(old[i]);
      if (!stall) begin
        if (m_wait.size() > 0) begin
          m_slot_valid = 1'b1;
          m_slot_pc = m_wait.pop_front();
        end else begin
          m_slot_valid = 1'b0;
        end
      end
    end
  endtask

  task automatic check_comb();
    bit exp_req;
    exp_req = !m_boot && !stall && !redirect;
    check("imem_req", imem_bus.imem_req_o, exp_req);
    check("imem_addr_lsb", imem_bus.imem_addr_o[1:0], 32'd0);
    if (exp_req) check("imem_addr", imem_bus.imem_addr_o, m_fetch_pc);
  endtask

  task automatic check_regs();
    logic [31:0] exp_instr;
    exp_instr = m_slot_valid ? mem_word(m_slot_pc) : NOP_INSTR;
    check("id_valid", id_valid, m_slot_valid);
    check("id_instr", id_instr, exp_instr);
    check("id_opcode", id_opcode, {25'd0, exp_instr[6:0]});
    check("misalign", misalign, m_misalign);
    if (m_slot_valid) begin
      check("id_pc", id_pc, m_slot_pc);
      check("id_pc_plus4", id_pc_plus4, m_slot_pc + 32'd4);
    end
  endtask

  // One clock cycle: drive inputs, check combinational request, advance.
  task automatic cycle(input bit s, input bit r, input logic [31:0] rpc);
    stall = s;
    redirect = r;
    redirect_pc = rpc;
    #1;
    check_comb();
    seen_req = imem_bus.imem_req_o;
    seen_addr = imem_bus.imem_addr_o;
    @(posedge clk);
    model_clock();
    #1;
    check_regs();
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_req"}, imem_bus.imem_req_o, 32'd0);
    check({tag, "_addr"}, imem_bus.imem_addr_o, RESET_PC);
    check({tag, "_valid"}, id_valid, 32'd0);
    check({tag, "_pc"}, id_pc, 32'd0);
    check({tag, "_pc_plus4"}, id_pc_plus4, 32'd4);
    check({tag, "_instr"}, id_instr, 32'h0000_0013);
    check({tag, "_opcode"}, id_opcode, 32'h13);
    check({tag, "_misalign"}, misalign, 32'd0);
  endtask

  // Pulse reset at the current (mid-cycle) point and release two edges later.
  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    stall = 1'b0;
    redirect = 1'b0;
    #1;
    model_reset();
    check_reset_values(tag);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int delivered;
    model_reset();
    @(posedge clk);
    #1;
    do_reset("reset");

    // Start-up: cycle 0 is BOOT, requests 0x0/0x4/0x8, first slot in cycle 3.
    cycle(0, 0, '0);
    check("boot_req", seen_req, 32'd0);
    cycle(0, 0, '0);
    check("start_req0", seen_req, 32'd1);
    check("start_addr0", seen_addr, 32'h0);
    cycle(0, 0, '0);
    check("start_addr1", seen_addr, 32'h4);
    check("start_valid_c3", id_valid, 32'd1);
    check("start_pc_c3", id_pc, 32'h0);
    check("start_instr_c3", id_instr, 32'h1000_0000);
    cycle(0, 0, '0);
    check("start_addr2", seen_addr, 32'h8);
    check("start_pc_c4", id_pc, 32'h4);
    cycle(0, 0, '0);
    check("start_pc_c5", id_pc, 32'h8);

    // Stall for 3 cycles with a response in flight.
    cycle(1, 0, '0);
    check("stall_hold_state", dut.state_q == HOLD, 32'd1);
    check("stall_hold_pc", id_pc, 32'h8);
    cycle(1, 0, '0);
    cycle(1, 0, '0);
    check("stall_still_pc", id_pc, 32'h8);
    cycle(0, 0, '0);
    check("stall_release_pc", id_pc, 32'hC);
    cycle(0, 0, '0);
    check("stall_next_pc", id_pc, 32'h10);

    // Redirect wins over a simultaneous stall.
    cycle(1, 1, 32'h100);
    check("redir_bubble1", id_valid, 32'd0);
    cycle(0, 0, '0);
    check("redir_bubble2", id_valid, 32'd0);
    cycle(0, 0, '0);
    check("redir_valid", id_valid, 32'd1);
    check("redir_pc", id_pc, 32'h100);
    check("redir_pc_plus4", id_pc_plus4, 32'h104);

    // Misaligned redirect target.
    cycle(0, 1, 32'h102);
    check("misalign_pulse", misalign, 32'd1);
    cycle(0, 0, '0);
    check("misalign_addr", seen_addr, 32'h100);
    check("misalign_drop", misalign, 32'd0);
    repeat (3) cycle(0, 0, '0);

    // Wrap-around of the fetch address.
    cycle(0, 1, 32'hFFFF_FFFC);
    cycle(0, 0, '0);
    check("wrap_addr_hi", seen_addr, 32'hFFFF_FFFC);
    cycle(0, 0, '0);
    check("wrap_addr_lo", seen_addr, 32'h0);
    check("wrap_pc", id_pc, 32'hFFFF_FFFC);
    check("wrap_pc_plus4", id_pc_plus4, 32'h0);
    repeat (2) cycle(0, 0, '0);

    // Reset pulsed while in HOLD.
    cycle(1, 0, '0);
    cycle(1, 0, '0);
    check("pre_reset_hold", dut.state_q == HOLD, 32'd1);
    do_reset("midreset");
    cycle(0, 0, '0);
    cycle(0, 0, '0);
    check("restart_addr", seen_addr, RESET_PC);
    check("restart_no_stale1", id_valid, 32'd0);
    cycle(0, 0, '0);
    check("restart_valid", id_valid, 32'd1);
    check("restart_pc", id_pc, RESET_PC);

    // Random stall/redirect traffic against the model.
    delivered = 0;
    for (int i = 0; i < 600; i++) begin
      bit s, r;
      logic [31:0] rpc;
      s = ($urandom_range(0, 3) == 0);
      r = ($urandom_range(0, 24) == 0);
      rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF))
                                        : ($urandom & 32'h0000_0FFF);
      cycle(s, r, rpc);
      if (id_valid === 1'b1 && !s) delivered++;
    end
    check("random_throughput", delivered > 150, 32'd1);

    stall = 1'b0;
    redirect = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
